// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data-memory bus, stalls upstream while an access is pending,
// and registers results into MEM/WB. Optional macro MISALIGN_TRAP_EN traps unaligned accesses.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res_mem,
    input  logic [31:0] write_data_mem,
    input  logic [4:0]  write_register_mem,
    input  logic [2:0]  m_mem,
    input  logic [1:0]  wb_mem,
    input  logic        zero_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        pc_src,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  write_register_wb,
    output logic [1:0]  wb_WB,
    output logic [31:0] write_data_reg,
    output logic        bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_exc
`endif
);

    // state  | meaning
    // IDLE   | no access outstanding; zero-wait completions finish here
    // WAIT   | request held, counting toward timeout
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             access_req;
    logic             misalign;
    logic             bus_access;
    logic             timeout_hit;
    logic             req_c;
    logic             stall_c;

    assign access_req = m_mem[1] | m_mem[0];

`ifdef MISALIGN_TRAP_EN
    assign misalign     = access_req && (res_mem[1:0] != 2'b00) && (state == ST_IDLE);
    assign misalign_exc = misalign & rst_n;
`else
    logic unused_lsb;
    assign misalign   = 1'b0;
    assign unused_lsb = ^res_mem[1:0];
`endif

    assign bus_access  = access_req & ~misalign;
    // cnt counts request cycles already spent, so the IDLE issue cycle is cycle 0
    assign timeout_hit = (state == ST_WAIT) && !dmem_ack && (cnt == CNT_LAST);

    always_comb begin
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state)
            ST_IDLE: begin
                req_c   = bus_access;
                stall_c = bus_access & ~dmem_ack;
            end
            ST_WAIT: begin
                req_c   = 1'b1;
                stall_c = ~dmem_ack & ~timeout_hit;
            end
            default: begin
                req_c   = 1'b0;
                stall_c = 1'b0;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held so a mid-access reset drops them at once
    assign dmem_req   = req_c & rst_n;
    assign stall_mem  = stall_c & rst_n;
    assign dmem_we    = m_mem[0] & dmem_req;
    assign dmem_addr  = {res_mem[31:2], 2'b00};
    assign dmem_wdata = write_data_mem;
    assign pc_src     = m_mem[2] & zero_mem;

    assign write_data_reg = wb_WB[0] ? read_data_wb : alu_res_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            read_data_wb      <= '0;
            alu_res_wb        <= '0;
            write_register_wb <= '0;
            wb_WB             <= '0;
            bus_err           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!access_req) begin
                        alu_res_wb        <= res_mem;
                        write_register_wb <= write_register_mem;
                        wb_WB             <= wb_mem;
                    end else if (misalign) begin
                        wb_WB <= 2'b00;
                    end else if (dmem_ack) begin
                        alu_res_wb        <= res_mem;
                        write_register_wb <= write_register_mem;
                        wb_WB             <= wb_mem;
                        read_data_wb      <= dmem_rdata;
                    end else begin
                        wb_WB <= 2'b00;
                        cnt   <= CNT_ONE;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        alu_res_wb        <= res_mem;
                        write_register_wb <= write_register_mem;
                        wb_WB             <= wb_mem;
                        read_data_wb      <= dmem_rdata;
                        cnt               <= '0;
                        state             <= ST_IDLE;
                    end else if (timeout_hit) begin
                        wb_WB   <= 2'b00;
                        bus_err <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        wb_WB <= 2'b00;
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] res_mem, write_data_mem, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] read_data_wb, alu_res_wb, write_data_reg;
    logic [4:0]  write_register_mem, write_register_wb;
    logic [2:0]  m_mem;
    logic [1:0]  wb_mem, wb_WB;
    logic        zero_mem, dmem_req, dmem_we, dmem_ack, stall_mem, pc_src, bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .res_mem(res_mem), .write_data_mem(write_data_mem),
        .write_register_mem(write_register_mem), .m_mem(m_mem), .wb_mem(wb_mem),
        .zero_mem(zero_mem), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .pc_src(pc_src), .read_data_wb(read_data_wb),
        .alu_res_wb(alu_res_wb), .write_register_wb(write_register_wb), .wb_WB(wb_WB),
        .write_data_reg(write_data_reg), .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
        , .misalign_exc(misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] wr,
                          input logic [2:0] m, input logic [1:0] wb);
        res_mem = res; write_data_mem = wd; write_register_mem = wr; m_mem = m; wb_mem = wb;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; zero_mem = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
        #12;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req actual=%b expected=0", dmem_req); end
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%b expected=0", stall_mem); end
        checks++; if ({read_data_wb, alu_res_wb, write_register_wb, wb_WB, bus_err} !== 72'h0) begin
            failures++; $display("FAIL reset_regs rd=%h alu=%h wr=%h wb=%b err=%b expected all 0",
                                 read_data_wb, alu_res_wb, write_register_wb, wb_WB, bus_err); end
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_op();
        set_in(32'h25, 32'h0, 5'd3, 3'b000, 2'b10);
        @(negedge clk);
        checks++; if ({dmem_req, stall_mem} !== 2'b00) begin failures++; $display("FAIL alu_req_stall actual=%b expected=00", {dmem_req, stall_mem}); end
        next_cycle();
        checks++; if (alu_res_wb !== 32'h25) begin failures++; $display("FAIL alu_res actual=%h expected=00000025", alu_res_wb); end
        checks++; if (write_data_reg !== 32'h25) begin failures++; $display("FAIL alu_wdreg actual=%h expected=00000025", write_data_reg); end
        checks++; if ({write_register_wb, wb_WB} !== {5'd3, 2'b10}) begin failures++; $display("FAIL alu_ctrl actual=%h/%b expected=03/10", write_register_wb, wb_WB); end
    endtask

    task automatic test_pc_src();
        set_in(32'h0, 32'h0, 5'd0, 3'b100, 2'b00); zero_mem = 1'b1;
        #1;
        checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL pc_src_taken actual=%b expected=1", pc_src); end
        zero_mem = 1'b0; #1;
        checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL pc_src_not_taken actual=%b expected=0", pc_src); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
        next_cycle();
    endtask

    task automatic test_load_zero_wait();
        set_in(32'h100, 32'h0, 5'd7, 3'b010, 2'b11);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEBABE;
        @(negedge clk);
        checks++; if ({dmem_req, dmem_we, stall_mem} !== 3'b100) begin failures++; $display("FAIL load0_bus req/we/stall actual=%b expected=100", {dmem_req, dmem_we, stall_mem}); end
        checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL load0_addr actual=%h expected=00000100", dmem_addr); end
        next_cycle();
        dmem_ack = 1'b0;
        checks++; if (read_data_wb !== 32'hCAFEBABE) begin failures++; $display("FAIL load0_rdata actual=%h expected=cafebabe", read_data_wb); end
        checks++; if (wb_WB !== 2'b11) begin failures++; $display("FAIL load0_wb actual=%b expected=11", wb_WB); end
        checks++; if (write_data_reg !== 32'hCAFEBABE) begin failures++; $display("FAIL load0_wdreg actual=%h expected=cafebabe", write_data_reg); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b10);
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL load0_req_one_cycle actual=%b expected=0", dmem_req); end
        next_cycle();
    endtask

    task automatic test_store_wait();
        int stall_cnt = 0;
        set_in(32'h40, 32'hDEADBEEF, 5'd0, 3'b001, 2'b00);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dmem_ack = 1'b1;
            @(negedge clk);
            if (stall_mem) stall_cnt++;
            checks++; if ({dmem_req, dmem_we} !== 2'b11 || dmem_wdata !== 32'hDEADBEEF || dmem_addr !== 32'h40) begin
                failures++; $display("FAIL store_bus cycle=%0d req/we=%b wdata=%h addr=%h expected=11/deadbeef/00000040",
                                     i, {dmem_req, dmem_we}, dmem_wdata, dmem_addr); end
            if (i >= 1) begin
                checks++; if (wb_WB !== 2'b00) begin failures++; $display("FAIL store_bubble cycle=%0d actual=%b expected=00", i, wb_WB); end
            end
            next_cycle();
        end
        dmem_ack = 1'b0;
        checks++; if (stall_cnt != 4) begin failures++; $display("FAIL store_stall_cycles actual=%0d expected=4", stall_cnt); end
        checks++; if (alu_res_wb !== 32'h40) begin failures++; $display("FAIL store_alu actual=%h expected=00000040", alu_res_wb); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
        next_cycle();
    endtask

    task automatic test_timeout();
        int  req_cnt = 0;
        bit  seen = 0;
        set_in(32'h200, 32'h0, 5'd9, 3'b010, 2'b11);
        dmem_ack = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dmem_req) req_cnt++;
            if (!stall_mem) seen = 1;
            next_cycle();
        end
        checks++; if (!seen) begin failures++; $display("FAIL timeout_bound stall still high after 40 cycles expected release"); end
        set_in(32'h77, 32'h0, 5'd4, 3'b000, 2'b10);
        checks++; if (req_cnt != 16) begin failures++; $display("FAIL timeout_req_cycles actual=%0d expected=16", req_cnt); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL timeout_bus_err actual=%b expected=1", bus_err); end
        checks++; if (wb_WB !== 2'b00) begin failures++; $display("FAIL timeout_bubble actual=%b expected=00", wb_WB); end
        @(negedge clk);
        checks++; if ({dmem_req, stall_mem} !== 2'b00) begin failures++; $display("FAIL timeout_resume actual=%b expected=00", {dmem_req, stall_mem}); end
        next_cycle();
        checks++; if ({alu_res_wb, wb_WB, bus_err} !== {32'h77, 2'b10, 1'b1}) begin
            failures++; $display("FAIL timeout_next_alu alu=%h wb=%b err=%b expected=00000077/10/1", alu_res_wb, wb_WB, bus_err); end
    endtask

    task automatic test_back_to_back();
        set_in(32'h10, 32'h0, 5'd1, 3'b010, 2'b11);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_AAAA;
        next_cycle();
        set_in(32'h14, 32'h0, 5'd2, 3'b010, 2'b11);
        dmem_rdata = 32'h2222_BBBB;
        @(negedge clk);
        checks++; if ({dmem_req, stall_mem, dmem_addr} !== {2'b10, 32'h14}) begin
            failures++; $display("FAIL b2b_second_req req/stall=%b addr=%h expected=10/00000014", {dmem_req, stall_mem}, dmem_addr); end
        checks++; if (read_data_wb !== 32'h1111_AAAA) begin failures++; $display("FAIL b2b_first_data actual=%h expected=1111aaaa", read_data_wb); end
        next_cycle();
        dmem_ack = 1'b0;
        checks++; if ({read_data_wb, write_register_wb} !== {32'h2222_BBBB, 5'd2}) begin
            failures++; $display("FAIL b2b_second_data actual=%h/%0d expected=2222bbbb/2", read_data_wb, write_register_wb); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b10);
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        set_in(32'h300, 32'h0, 5'd5, 3'b010, 2'b11);
        dmem_ack = 1'b0;
        next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if ({dmem_req, stall_mem} !== 2'b11) begin failures++; $display("FAIL rstwait_pending actual=%b expected=11", {dmem_req, stall_mem}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req, stall_mem} !== 2'b00) begin failures++; $display("FAIL rstwait_drop actual=%b expected=00", {dmem_req, stall_mem}); end
        checks++; if ({read_data_wb, alu_res_wb, wb_WB, bus_err, write_data_reg} !== 99'h0) begin
            failures++; $display("FAIL rstwait_regs rd=%h alu=%h wb=%b err=%b wd=%h expected all 0",
                                 read_data_wb, alu_res_wb, wb_WB, bus_err, write_data_reg); end
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
        dmem_ack = 1'b0;
        checks++; if ({read_data_wb, dmem_req} !== 33'h0) begin failures++; $display("FAIL rstwait_late_ack rd=%h req=%b expected=0/0", read_data_wb, dmem_req); end
    endtask

    task automatic test_misalign();
        set_in(32'h55, 32'h0, 5'd6, 3'b000, 2'b10);
        next_cycle();
        set_in(32'h102, 32'h0, 5'd6, 3'b010, 2'b11);
        dmem_rdata = 32'h0BAD_F00D;
`ifdef MISALIGN_TRAP_EN
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({dmem_req, stall_mem, misalign_exc} !== 3'b001) begin
            failures++; $display("FAIL misalign_trap req/stall/exc actual=%b expected=001", {dmem_req, stall_mem, misalign_exc}); end
        next_cycle();
        checks++; if (wb_WB !== 2'b00) begin failures++; $display("FAIL misalign_bubble actual=%b expected=00", wb_WB); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
        @(negedge clk);
        checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL misalign_pulse actual=%b expected=0", misalign_exc); end
`else
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h100}) begin
            failures++; $display("FAIL misalign_mask req=%b addr=%h expected=1/00000100", dmem_req, dmem_addr); end
        next_cycle();
        dmem_ack = 1'b0;
        checks++; if ({wb_WB, read_data_wb} !== {2'b11, 32'h0BAD_F00D}) begin
            failures++; $display("FAIL misalign_load wb=%b rd=%h expected=11/0badf00d", wb_WB, read_data_wb); end
        set_in(32'h0, 32'h0, 5'd0, 3'b000, 2'b00);
`endif
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_pc_src();
        test_load_zero_wait();
        test_store_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM pipeline register (ALU result, store data, destination register, M and WB control).
- Drives a req/ack data-memory bus, stalls upstream stages while an access is outstanding, and registers results into the MEM/WB pipeline register.
- Supplies the write-back value and control consumed by the forwarding unit.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for dmem_ack before the access is aborted.
- CNT_W, 5: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- res_mem  in  32  ALU result; memory address for loads and stores
- write_data_mem  in  32  store data
- write_register_mem  in  5  destination register
- m_mem  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- wb_mem  in  2  [1]=reg_write, [0]=mem_to_reg
- zero_mem  in  1  ALU zero flag
- dmem_req  out  1  access request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word address ({res_mem[31:2],2'b00})
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  load data
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- pc_src  out  1  branch taken (m_mem[2] & zero_mem), combinational
- read_data_wb  out  32  registered load data
- alu_res_wb  out  32  registered ALU result
- write_register_wb  out  5  registered destination register
- wb_WB  out  2  registered WB control
- write_data_reg  out  32  wb_WB[0] ? read_data_wb : alu_res_wb
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, active-low):
  - FSM returns to IDLE; counter=0.
  - All registered outputs are 0; bus_err=0.
  - dmem_req deasserts immediately, including mid-access. A late ack after reset is ignored.
- An access is needed when m_mem[1] or m_mem[0] is set. If both are set, the access is a write.
- FSM states:
  - IDLE:
    - No access needed: stall_mem=0 and the MEM/WB register loads the inputs on the next edge (1-cycle latency).
    - Access needed: dmem_req=1 combinationally, with dmem_addr, dmem_we and dmem_wdata driven from the inputs.
    - dmem_ack in the same cycle: zero-wait completion, stall_mem=0, MEM/WB loads, read_data_wb<=dmem_rdata.
    - No ack: stall_mem=1, MEM/WB loads a bubble (wb_WB<=0), go to WAIT.
  - WAIT:
    - dmem_req held at 1 with stable address and data. Inputs are stable because upstream is frozen.
    - counter increments each cycle.
    - On ack: stall_mem=0, MEM/WB loads the instruction, counter=0, go to IDLE.
    - If counter==TIMEOUT_CYCLES-1 with no ack: drop req, set bus_err, stall_mem=0, MEM/WB loads a bubble, go to IDLE.
- Timing of an access:
  - A new request can issue on the cycle after completion.
  - A store completes with no register write unless wb_mem[1] is set.
- stall_mem is combinational: (access needed & !dmem_ack) in IDLE, and !dmem_ack in WAIT except on the timeout cycle.
- Bubbles and flags:
  - A bubble clears wb_WB only. Data fields keep their previous values.
  - bus_err is sticky until reset.
- pc_src is purely combinational and is not gated by stall.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - If res_mem[1:0]!=0 during an access, no dmem_req is issued.
  - Output misalign_exc (1 bit) pulses high for one cycle.
  - MEM/WB loads a bubble and stall_mem=0.
- Undefined:
  - The misalign_exc port is absent.
  - Low address bits are ignored by masking.

Test Plan:
- ALU op, wb_mem=2'b10, res_mem=0x25, m_mem=0 -> next edge alu_res_wb=0x25, write_data_reg=0x25, stall_mem never high, dmem_req never high.
- Load, res_mem=0x100, ack tied high -> dmem_req with dmem_addr=0x100 and dmem_we=0 for 1 cycle; next edge read_data_wb=dmem_rdata=0xCAFEBABE, wb_WB=2'b11, write_data_reg=0xCAFEBABE.
- Store 0xDEADBEEF to 0x40, ack after 3 wait cycles -> stall_mem high for 4 cycles, dmem_we=1 and wdata stable throughout, wb_WB=0 during the stall cycles.
- Load with ack never asserted, TIMEOUT_CYCLES=16 -> req high exactly 16 cycles then low, bus_err=1 and stays 1, pipeline resumes, a following ALU op writes back normally.
- rst_n low in WAIT -> dmem_req and stall_mem drop in the same cycle, all outputs 0; a subsequent ack is ignored.
- MISALIGN_TRAP_EN defined, load at 0x102 -> no dmem_req, misalign_exc pulses once, wb_WB=0. Undefined: dmem_addr=0x100.
